// File: rtl/lru_victim_ctrl.sv
// Miss/replacement controller for one 8-way set: issues LRU hit touches, picks a
// victim on a miss, runs the refill handshake and issues the fill touch.
module lru_victim_ctrl #(
  parameter int AGE_W   = 3,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_lookup_valid,
  input  logic             i_hit_sig,
  input  logic [7:0]       i_hit_way_8,
  output logic             o_lookup_ready,
  input  logic [AGE_W-1:0] i_age0,
  input  logic [AGE_W-1:0] i_age1,
  input  logic [AGE_W-1:0] i_age2,
  input  logic [AGE_W-1:0] i_age3,
  input  logic [AGE_W-1:0] i_age4,
  input  logic [AGE_W-1:0] i_age5,
  input  logic [AGE_W-1:0] i_age6,
  input  logic [AGE_W-1:0] i_age7,
  input  logic [7:0]       i_invalidate,
  output logic             o_refill_req,
  output logic [2:0]       o_refill_way,
  input  logic             i_refill_ack,
  output logic             o_refill_err,
  output logic [7:0]       o_lru_way_8,
  output logic             o_lru_write_en,
  output logic             o_lru_hit_sig,
  output logic [7:0]       o_valid_ways
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VICTIM = 2'd1;
  localparam logic [1:0] S_REQ    = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [1:0]         r_state;
  logic [7:0]         r_valid;
  logic [8*AGE_W-1:0] r_ages;
  logic [2:0]         r_victim;
  logic [CNT_W-1:0]   r_tcnt;
  logic [7:0]         r_lru_way;
  logic               r_lru_we;
  logic               r_lru_hit;
  logic               r_err;

  logic [8*AGE_W-1:0] w_ages_in;
  logic               w_onehot;
  logic               w_hit;
  logic               w_miss;
  logic               w_timeout;
  logic [7:0]         w_set_mask;
  logic [2:0]         w_victim;
  logic               w_found;
  logic [AGE_W-1:0]   w_max_age;

  assign w_ages_in  = {i_age7, i_age6, i_age5, i_age4, i_age3, i_age2, i_age1, i_age0};
  assign w_onehot   = (i_hit_way_8 != 8'd0) && ((i_hit_way_8 & (i_hit_way_8 - 8'd1)) == 8'd0);
  assign w_hit      = i_lookup_valid & i_hit_sig & w_onehot;
  assign w_miss     = i_lookup_valid & ~w_hit;
  assign w_timeout  = (TIMEOUT != 0) && (r_tcnt == CNT_W'(TIMEOUT - 1));
  assign w_set_mask = (r_state == S_UPDATE) ? (8'd1 << r_victim) : 8'd0;

  // Invalid ways first; otherwise the strict-greater max scan yields the lowest
  // index among the oldest ways, which is also the first way at age 7.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_victim  = 3'd0;
    w_found   = 1'b0;
    w_max_age = r_ages[AGE_W-1:0];
    for (int i = 0; i < 8; i++) begin
      if (!w_found && !r_valid[i]) begin
        w_victim = 3'(i);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int i = 1; i < 8; i++) begin
        if (r_ages[i*AGE_W +: AGE_W] > w_max_age) begin
          w_max_age = r_ages[i*AGE_W +: AGE_W];
          w_victim  = 3'(i);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 8'd0;
      r_ages    <= '0;
      r_victim  <= 3'd0;
      r_tcnt    <= '0;
      r_lru_way <= 8'd0;
      r_lru_we  <= 1'b0;
      r_lru_hit <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_lru_way <= 8'd0;
      r_lru_we  <= 1'b0;
      r_lru_hit <= 1'b0;
      r_err     <= 1'b0;
      // The fill set is OR-ed after the clear so a same-way invalidate loses.
      r_valid   <= (r_valid & ~i_invalidate) | w_set_mask;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_lru_way <= i_hit_way_8;
            r_lru_we  <= 1'b1;
            r_lru_hit <= 1'b1;
          end else if (w_miss) begin
            r_ages  <= w_ages_in;
            r_state <= S_VICTIM;
          end
        end
        S_VICTIM: begin
          r_victim <= w_victim;
          r_tcnt   <= '0;
          r_state  <= S_REQ;
        end
        S_REQ: begin
          if (i_refill_ack) begin
            r_lru_way <= 8'd1 << r_victim;
            r_lru_we  <= 1'b1;
            r_state   <= S_UPDATE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_UPDATE: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_lookup_ready = (r_state == S_IDLE);
  assign o_refill_req   = (r_state == S_REQ);
  assign o_refill_way   = o_refill_req ? r_victim : 3'd0;
  assign o_refill_err   = r_err;
  assign o_lru_way_8    = r_lru_way;
  assign o_lru_write_en = r_lru_we;
  assign o_lru_hit_sig  = r_lru_hit;
  assign o_valid_ways   = r_valid;

endmodule

// File: tb/tb_lru_victim_ctrl.sv
// Directed bench for lru_victim_ctrl: a per-cycle vector table followed by
// hand-written refill, latching, timeout and reset sequences.
module tb_lru_victim_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv = 1'b0, hs = 1'b0, ack = 1'b0;
  logic [7:0] hw = 8'd0, inv = 8'd0;
  logic [2:0] age [8];
  logic       ready, req, err, we, lhs;
  logic [2:0] way;
  logic [7:0] lru, valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lru_victim_ctrl #(.AGE_W(3), .TIMEOUT(200)) dut (
    .clk(clk), .rst(rst),
    .i_lookup_valid(lv), .i_hit_sig(hs), .i_hit_way_8(hw), .o_lookup_ready(ready),
    .i_age0(age[0]), .i_age1(age[1]), .i_age2(age[2]), .i_age3(age[3]),
    .i_age4(age[4]), .i_age5(age[5]), .i_age6(age[6]), .i_age7(age[7]),
    .i_invalidate(inv), .o_refill_req(req), .o_refill_way(way), .i_refill_ack(ack),
    .o_refill_err(err), .o_lru_way_8(lru), .o_lru_write_en(we), .o_lru_hit_sig(lhs),
    .o_valid_ways(valid)
  );

  typedef struct {
    logic       lv;
    logic       hs;
    logic [7:0] hw;
    logic [7:0] inv;
    logic       ack;
    logic       e_rdy;
    logic       e_req;
    logic [2:0] e_way;
    logic [7:0] e_lru;
    logic       e_we;
    logic       e_lhs;
    logic [7:0] e_valid;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ages(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                          input logic [2:0] a3, input logic [2:0] a4, input logic [2:0] a5,
                          input logic [2:0] a6, input logic [2:0] a7);
    age[0] = a0; age[1] = a1; age[2] = a2; age[3] = a3;
    age[4] = a4; age[5] = a5; age[6] = a6; age[7] = a7;
  endtask

  // Miss, immediate ack, fill; live ages are scrambled after the sample edge so
  // the victim must come from the latched copy.
  task automatic miss_fill(input logic [2:0] exp_way, input string tag);
    lv = 1'b1; hs = 1'b0; hw = 8'd0;
    tick();
    lv = 1'b0;
    for (int i = 0; i < 8; i++) age[i] = 3'd7;
    check({tag, "_victim_rdy"}, 32'(ready), 32'd0);
    tick();
    check({tag, "_req"}, 32'(req), 32'd1);
    check({tag, "_way"}, 32'(way), 32'(exp_way));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_upd_req"}, 32'(req), 32'd0);
    check({tag, "_upd_we"}, 32'(we), 32'd1);
    check({tag, "_upd_lru"}, 32'(lru), 32'(8'd1 << exp_way));
    check({tag, "_upd_lhs"}, 32'(lhs), 32'd0);
    tick();
    check({tag, "_valid_bit"}, 32'(valid[exp_way]), 32'd1);
    check({tag, "_idle_rdy"}, 32'(ready), 32'd1);
    check({tag, "_idle_we"}, 32'(we), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    set_ages(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    //          lv    hs    hw     inv    ack   rdy   req   way   lru    we    lhs   valid
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h01};
    vecs[7]  = '{1'b1, 1'b1, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h20, 1'b1, 1'b1, 8'h01};
    vecs[8]  = '{1'b1, 1'b1, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h04, 1'b1, 1'b1, 8'h01};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h01};
    vecs[10] = '{1'b1, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h01};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 8'h01};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h02, 1'b1, 1'b0, 8'h01};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h03};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h03};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h02};

    // Reset state
    #2;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      lv = vecs[i].lv; hs = vecs[i].hs; hw = vecs[i].hw; inv = vecs[i].inv; ack = vecs[i].ack;
      tick();
      check($sformatf("v%0d_rdy", i), 32'(ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_req", i), 32'(req), 32'(vecs[i].e_req));
      check($sformatf("v%0d_way", i), 32'(way), 32'(vecs[i].e_way));
      check($sformatf("v%0d_lru", i), 32'(lru), 32'(vecs[i].e_lru));
      check($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_lhs", i), 32'(lhs), 32'(vecs[i].e_lhs));
      check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_err", i), 32'(err), 32'd0);
    end
    lv = 1'b0; hs = 1'b0; hw = 8'd0; inv = 8'd0; ack = 1'b0;

    // Fill remaining invalid ways in lowest-index order (valid starts at 8'h02)
    miss_fill(3'd0, "fill0");
    miss_fill(3'd2, "fill2");
    miss_fill(3'd3, "fill3");
    miss_fill(3'd4, "fill4");
    miss_fill(3'd5, "fill5");
    miss_fill(3'd6, "fill6");
    miss_fill(3'd7, "fill7");
    check("all_valid", 32'(valid), 32'hFF);

    // All valid: first age-7 way, then max age with lowest-index tie
    set_ages(3'd3, 3'd1, 3'd7, 3'd0, 3'd2, 3'd4, 3'd5, 3'd6);
    miss_fill(3'd2, "age7");
    set_ages(3'd3, 3'd1, 3'd5, 3'd0, 3'd6, 3'd4, 3'd6, 3'd2);
    miss_fill(3'd4, "maxage");

    // Delayed ack with lookups driven; victim invalidated mid-REQ; set beats clear
    set_ages(3'd3, 3'd1, 3'd7, 3'd0, 3'd2, 3'd4, 3'd5, 3'd6);
    lv = 1'b1; hs = 1'b0;
    tick();
    tick();
    check("dly_req_rise", 32'(req), 32'd1);
    check("dly_way_rise", 32'(way), 32'd2);
    for (int k = 0; k < 10; k++) begin
      lv = 1'b1; hs = k[0]; hw = 8'h01 << (k % 8);
      inv = (k == 3) ? 8'h04 : 8'h00;
      tick();
      check($sformatf("dly%0d_rdy", k), 32'(ready), 32'd0);
      check($sformatf("dly%0d_req", k), 32'(req), 32'd1);
      check($sformatf("dly%0d_way", k), 32'(way), 32'd2);
      check($sformatf("dly%0d_we", k), 32'(we), 32'd0);
    end
    check("dly_inv_valid", 32'(valid), 32'hFB);
    lv = 1'b0; hs = 1'b0; hw = 8'd0; inv = 8'd0; ack = 1'b1;
    tick();
    ack = 1'b0;
    check("dly_upd_we", 32'(we), 32'd1);
    check("dly_upd_lru", 32'(lru), 32'h04);
    check("dly_upd_lhs", 32'(lhs), 32'd0);
    inv = 8'h04;
    tick();
    inv = 8'h00;
    check("conflict_valid", 32'(valid), 32'hFF);
    check("conflict_rdy", 32'(ready), 32'd1);

    // Timeout after exactly 200 REQ cycles
    lv = 1'b1; hs = 1'b0;
    tick();
    lv = 1'b0;
    tick();
    check("to_req_rise", 32'(req), 32'd1);
    n = 0;
    while (req === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    check("to_req_cycles", 32'(n), 32'd200);
    check("to_err_pulse", 32'(err), 32'd1);
    check("to_ready", 32'(ready), 32'd1);
    check("to_valid", 32'(valid), 32'hFF);
    check("to_we", 32'(we), 32'd0);
    tick();
    check("to_err_drop", 32'(err), 32'd0);
    check("to_we_after", 32'(we), 32'd0);

    // Asynchronous reset mid-REQ
    lv = 1'b1; hs = 1'b0;
    tick();
    lv = 1'b0;
    tick();
    check("rr_req", 32'(req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rr_req_drop", 32'(req), 32'd0);
    check("rr_valid", 32'(valid), 32'd0);
    check("rr_ready", 32'(ready), 32'd1);
    tick();
    rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("rr_no_strobe", 32'(we), 32'd0);
    check("rr_idle_req", 32'(req), 32'd0);
    miss_fill(3'd0, "rrfill");
    check("rr_fill_valid", 32'(valid), 32'h01);
    inv = 8'hFF;
    tick();
    inv = 8'h00;
    check("inv_all", 32'(valid), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
